// File: rtl/uram_read_streamer.sv
// uram_read_streamer: valid/ready read front end for the fixed-latency URAM read port; ports clock/reset, req_valid/req_ready/req_addr in, rsp_valid/rsp_ready/rsp_data out, mem_raddr/mem_dout to the wrapper; define URAM_READ_BYPASS_EN for empty-FIFO bypass
module uram_read_streamer #(
  parameter int DATA_WIDTH    = 64,
  parameter int ADDRESS_WIDTH = 12,
  parameter int READ_LATENCY  = 2,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [ADDRESS_WIDTH-1:0] req_addr,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [DATA_WIDTH-1:0]    rsp_data,
  output logic [ADDRESS_WIDTH-1:0] mem_raddr,
  input  logic [DATA_WIDTH-1:0]    mem_dout
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  logic [READ_LATENCY-1:0] vpipe_q, vpipe_d;
  logic [READ_LATENCY:0]   vsh;
  logic [PW-1:0]           wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]           fifo_cnt_q, fifo_cnt_d, infl_q, infl_d;
  logic [DATA_WIDTH-1:0]   fifo_mem [FIFO_DEPTH];
  logic                    accept, capture, wr_en, pop, not_empty;
`ifdef URAM_READ_BYPASS_EN
  logic                    byp;
`endif
  assign mem_raddr = req_addr;
  always_comb begin
    req_ready = (infl_q + fifo_cnt_q) < CW'(FIFO_DEPTH);
    accept    = req_valid & req_ready;
    capture   = vpipe_q[READ_LATENCY-1];
    not_empty = fifo_cnt_q != '0;
`ifdef URAM_READ_BYPASS_EN
    byp       = capture & ~not_empty;
    rsp_valid = not_empty | byp;
    rsp_data  = not_empty ? fifo_mem[rptr_q] : byp ? mem_dout : '0;
    wr_en     = capture & ~(byp & rsp_ready);
    pop       = not_empty & rsp_ready;
`else
    rsp_valid = not_empty;
    rsp_data  = not_empty ? fifo_mem[rptr_q] : '0;
    wr_en     = capture;
    pop       = not_empty & rsp_ready;
`endif
    vsh        = {vpipe_q, accept};
    vpipe_d    = vsh[READ_LATENCY-1:0];
    infl_d     = infl_q + CW'(accept) - CW'(capture);
    fifo_cnt_d = fifo_cnt_q + CW'(wr_en) - CW'(pop);
    wptr_d     = wr_en ? (wptr_q == PW'(FIFO_DEPTH - 1) ? '0 : wptr_q + 1'b1) : wptr_q;
    rptr_d     = pop ? (rptr_q == PW'(FIFO_DEPTH - 1) ? '0 : rptr_q + 1'b1) : rptr_q;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      vpipe_q    <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      fifo_cnt_q <= '0;
      infl_q     <= '0;
    end else begin
      vpipe_q    <= vpipe_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      fifo_cnt_q <= fifo_cnt_d;
      infl_q     <= infl_d;
    end
  end
  always_ff @(posedge clock) begin
    if (wr_en) fifo_mem[wptr_q] <= mem_dout;
  end
endmodule

// File: tb/tb_uram_read_streamer.sv
// tb_uram_read_streamer: randomized and directed check of uram_read_streamer against a queue-based reference model
module tb_uram_read_streamer;
  localparam int DW = 64;
  localparam int AW = 12;
  localparam int RL = 2;
  localparam int DEPTH = 4;
`ifdef URAM_READ_BYPASS_EN
  localparam int LAT = RL;
`else
  localparam int LAT = RL + 1;
`endif
  logic clock = 0, reset = 1, req_valid = 0, req_ready, rsp_valid, rsp_ready = 0;
  logic [AW-1:0] req_addr = '0, mem_raddr;
  logic [DW-1:0] rsp_data, mem_dout, d1, d2;
  logic [DW-1:0] ram [1 << AW];
  typedef struct { logic [DW-1:0] d; int rdy; } ent_t;
  ent_t q[$];
  int total = 0, bad = 0, cyc = 0, nacc = 0;
  uram_read_streamer #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .READ_LATENCY(RL), .FIFO_DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .mem_raddr(mem_raddr), .mem_dout(mem_dout)
  );
  always #5 clock = ~clock;
  always_ff @(posedge clock) begin
    d1 <= ram[mem_raddr];
    d2 <= d1;
  end
  assign mem_dout = d2;
  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask
  task automatic step(input logic v, input logic [AW-1:0] a, input logic r, input logic rs);
    logic exp_rdy, exp_v;
    ent_t e;
    req_valid = v;
    req_addr = a;
    rsp_ready = r;
    reset = rs;
    @(negedge clock);
    if (rs) q.delete();
    else begin
      exp_rdy = q.size() < DEPTH;
      exp_v = q.size() > 0 && q[0].rdy <= cyc;
      chk("req_ready", {63'd0, req_ready}, {63'd0, exp_rdy});
      chk("rsp_valid", {63'd0, rsp_valid}, {63'd0, exp_v});
      if (exp_v) chk("rsp_data", rsp_data, q[0].d);
      if (exp_v && r) void'(q.pop_front());
      if (v && exp_rdy) begin
        e.d = ram[a];
        e.rdy = cyc + LAT;
        q.push_back(e);
        nacc++;
      end
    end
    @(posedge clock);
    #1;
    cyc++;
  endtask
  task automatic post_reset_chk();
    chk("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    chk("rst_req_ready", {63'd0, req_ready}, 64'd1);
    chk("rst_rsp_data", rsp_data, 64'd0);
  endtask
  initial begin
    for (int i = 0; i < (1 << AW); i++) ram[i] = {$urandom, $urandom};
    @(posedge clock);
    #1;
    for (int i = 0; i < 3; i++) step(0, 0, 1, 1);
    post_reset_chk();
    ram[5] = 64'hDEAD_BEEF_0000_0001;
    while (cyc < 10) step(0, 0, 1, 0);
    step(1, 12'h005, 1, 0);
    for (int i = 0; i < 6; i++) step(0, 0, 1, 0);
    for (int i = 0; i < 64; i++) ram[i] = 64'(i * 3);
    for (int i = 0; i < 64; i++) step(1, AW'(i), 1, 0);
    for (int i = 0; i < 6; i++) step(0, 0, 1, 0);
    nacc = 0;
    for (int i = 0; i < 8; i++) step(1, AW'($urandom), 0, 0);
    chk("bp_accepts", 64'(nacc), 64'(DEPTH));
    for (int i = 0; i < 12; i++) step(1, AW'($urandom), 1, 0);
    for (int i = 0; i < 20; i++) step(1'($urandom), AW'($urandom), $urandom_range(0, 3) != 0, 0);
    for (int i = 0; i < 6; i++) step(0, 0, 1, 0);
    for (int i = 0; i < 4; i++) step(1, AW'($urandom), 0, 0);
    step(0, 0, 1, 1);
    post_reset_chk();
    for (int i = 0; i < RL + 2; i++) step(0, 0, 1, 0);
    for (int i = 0; i < 10000; i++) step(1'($urandom), AW'($urandom), 1'($urandom), 0);
    for (int i = 0; i < 8; i++) step(0, 0, 1, 0);
    chk("drained", 64'(q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uram_read_streamer.md
Name: uram_read_streamer

Overview:
- Latency-tolerant front end for the read port of the URAM wrapper. It converts a valid/ready stream of read addresses into the wrapper's fixed-latency raddr/dout interface.
- It tracks in-flight reads in a valid shift register and lands returning data in a small response FIFO. This lets downstream consumers apply backpressure without data loss.
- It sits directly upstream of the URAM raddr input and downstream of its dout output. The write port is not touched.

Parameters:
- DATA_WIDTH, 64, width of read data; matches URAM wrapper DATA_WIDTH.
- ADDRESS_WIDTH, 12, width of read address; matches URAM wrapper ADDRESS_WIDTH.
- READ_LATENCY, 2, clock edges from raddr presented to dout valid in the URAM wrapper; legal range ≥1.
- FIFO_DEPTH, 4, response FIFO entries; must be ≥ READ_LATENCY+2 for full throughput; legal range ≥ READ_LATENCY+1.

Ports:
- clock  in  1  sole clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  read request valid.
- req_ready  out  1  block can accept a request this cycle.
- req_addr  in  ADDRESS_WIDTH  read address.
- rsp_valid  out  1  rsp_data holds a valid response.
- rsp_ready  in  1  consumer accepts the response this cycle.
- rsp_data  out  DATA_WIDTH  read data, returned in request order.
- mem_raddr  out  ADDRESS_WIDTH  to URAM wrapper raddr.
- mem_dout  in  DATA_WIDTH  from URAM wrapper dout.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high, sampled on the rising edge of clock.
- State after reset: valid pipe, FIFO read/write pointers, fifo_count and inflight_count all cleared to 0.
  - Outputs after reset: rsp_valid=0, req_ready=1, rsp_data=0 (FIFO storage itself need not be cleared).
- Request acceptance:
  - accept = req_valid & req_ready.
  - req_ready = (inflight_count + fifo_count) < FIFO_DEPTH.
  - req_ready depends on registered state only; there is no combinational path from rsp_ready or req_valid.
- Address path: mem_raddr = req_addr, combinational. The URAM reads every cycle; non-accepted cycles produce data that is ignored.
- Valid pipe:
  - READ_LATENCY bits; vpipe[0] <= accept and vpipe[i] <= vpipe[i-1].
  - For a request accepted in cycle t, vpipe[READ_LATENCY-1] is high during cycle t+READ_LATENCY, aligned with mem_dout holding that request's data.
- Capture: when vpipe[READ_LATENCY-1]=1, mem_dout is written to FIFO[wptr] at the end of that cycle.
- Pop: pop = rsp_valid & rsp_ready. rsp_valid = fifo_count != 0. rsp_data = FIFO[rptr].
- Latency: accept in cycle t gives rsp_valid in cycle t+READ_LATENCY+1, provided the FIFO was empty.
- Counters:
  - inflight_count increments on accept and decrements on capture; same-cycle accept and capture leaves it unchanged.
  - fifo_count increments on capture and decrements on pop; simultaneous capture and pop leaves it unchanged.
- Pointers wrap from FIFO_DEPTH-1 to 0 (FIFO_DEPTH need not be a power of two).
- Throughput: with rsp_ready held at 1 and FIFO_DEPTH ≥ READ_LATENCY+2, one request is accepted per cycle indefinitely.
- Ordering: responses are returned strictly in acceptance order.
- Overflow: capture into a full FIFO cannot occur, because the credit rule guarantees it.
- Reset mid-operation:
  - All in-flight reads and buffered responses are discarded.
  - Data returning from the URAM in the cycles after reset is not captured, because vpipe is cleared.

Optional Feature:
- Macro: URAM_READ_BYPASS_EN.
- With the macro defined, when fifo_count==0 and vpipe[READ_LATENCY-1]=1:
  - rsp_valid=1 and rsp_data=mem_dout, combinationally.
  - If rsp_ready=1 in that cycle, the entry is not written to the FIFO and fifo_count is unchanged.
  - Empty-FIFO latency becomes READ_LATENCY cycles.
- Without the macro, rsp_data is always driven from FIFO storage. Latency is READ_LATENCY+1 cycles, and rsp_valid/rsp_data are free of combinational input paths.

Test Plan:
- Single read: URAM preloaded with addr 0x005 = 0xDEAD_BEEF_0000_0001; one request at cycle 10 with rsp_ready=1.
  -> rsp_valid high only in cycle 13 (READ_LATENCY=2) with that data; cycle 12 if URAM_READ_BYPASS_EN.
- Streaming: 64 back-to-back requests to addresses 0..63, each holding data = addr*3, with rsp_ready=1.
  -> req_ready never drops; 64 responses on consecutive cycles, in order, each equal to addr*3.
- Backpressure: rsp_ready=0 while req_valid=1 continuously.
  -> exactly FIFO_DEPTH=4 requests accepted, then req_ready=0; after rsp_ready=1, 4 correct in-order responses and acceptance resumes.
- Simultaneous capture and pop with FIFO at 3 entries and rsp_ready=1.
  -> fifo_count stays 3; pointers wrap past 3→0 with no corruption across 20 cycles of random stimulus checked against a reference queue.
- Reset mid-flight: 2 requests in flight plus 2 buffered; reset asserted for 1 cycle.
  -> next cycle rsp_valid=0 and req_ready=1; no stale response appears within READ_LATENCY+2 cycles.
- Random soak: random req_valid/rsp_ready at 50% each, 10k cycles, against a scoreboard.
  -> zero mismatches and no overflow; fifo_count ≤ 4 at all times.
